sdp_ram: RTL and testbench

SDP_RAM -- requirements
Module: sdp_ram

---
 rtl/sdp_ram_if.sv | 26 ++
 rtl/sdp_ram.sv | 108 ++++++++++
 tb/tb_sdp_ram.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/sdp_ram_if.sv
// Bundles the write port (A) and read port (B) of sdp_ram for a bus-style master.
interface sdp_ram_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32
);
  logic                  wea;
  logic [ADDR_W-1:0]     addra;
  logic [DATA_W-1:0]     dina;
  logic [DATA_W/8-1:0]   wstrba;
  logic                  reb;
  logic [ADDR_W-1:0]     addrb;
  logic [DATA_W-1:0]     doutb;
  logic                  doutb_valid;
  logic                  erra;
  logic                  errb;

  modport master (
    output wea, addra, dina, wstrba, reb, addrb,
    input  doutb, doutb_valid, erra, errb
  );

  modport slave (
    input  wea, addra, dina, wstrba, reb, addrb,
    output doutb, doutb_valid, erra, errb
  );
endinterface

// File: rtl/sdp_ram.sv
// Simple dual-port byte-addressed RAM: byte-strobed write port A, registered read port B.
// Define SDP_RAM_BYPASS_EN for write-first collisions; otherwise read-first (plain block RAM).
module sdp_ram #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned ADDR_W = 32
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                wea,
  input  logic [ADDR_W-1:0]   addra,
  input  logic [DATA_W-1:0]   dina,
  input  logic [DATA_W/8-1:0] wstrba,
  input  logic                reb,
  input  logic [ADDR_W-1:0]   addrb,
  output logic [DATA_W-1:0]   doutb,
  output logic                doutb_valid,
  output logic                erra,
  output logic                errb
);
  localparam int unsigned NLANE = DATA_W / 8;
  localparam int unsigned OFS   = $clog2(NLANE);
  localparam int unsigned IDX   = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  logic [IDX-1:0]    wr_idx;
  logic [IDX-1:0]    rd_idx;
  logic              mis_a;
  logic              mis_b;
  logic              wr_en;
  logic              rd_en;
  logic [DATA_W-1:0] rd_word;

  logic [DATA_W-1:0] doutb_q, doutb_d;
  logic              valid_q, valid_d;
  logic              erra_q,  erra_d;
  logic              errb_q,  errb_d;

  // Upper address bits are intentionally ignored so accesses wrap modulo DEPTH.
  logic unused_addr;
  assign unused_addr = ^{addra, addrb};

  assign wr_idx = addra[OFS+IDX-1:OFS];
  assign rd_idx = addrb[OFS+IDX-1:OFS];

  generate
    if (OFS == 0) begin : g_byte_wide
      assign mis_a = 1'b0;
      assign mis_b = 1'b0;
    end else begin : g_multi_byte
      assign mis_a = |addra[OFS-1:0];
      assign mis_b = |addrb[OFS-1:0];
    end
  endgenerate

  // Writes are gated by rstn here rather than by resetting the array, so contents survive reset.
  always_comb begin
    wr_en = wea & ~mis_a & rstn;
    rd_en = reb & ~mis_b;
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int unsigned i = 0; i < NLANE; i++) begin
        if (wstrba[i]) begin
          mem[wr_idx][i*8 +: 8] <= dina[i*8 +: 8];
        end
      end
    end
  end

  always_comb begin
    rd_word = mem[rd_idx];
`ifdef SDP_RAM_BYPASS_EN
    if (wr_en && (wr_idx == rd_idx)) begin
      for (int unsigned i = 0; i < NLANE; i++) begin
        if (wstrba[i]) begin
          rd_word[i*8 +: 8] = dina[i*8 +: 8];
        end
      end
    end
`endif
    doutb_d = rd_en ? rd_word : doutb_q;
    valid_d = rd_en;
    erra_d  = wea & mis_a;
    errb_d  = reb & mis_b;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      doutb_q <= '0;
      valid_q <= 1'b0;
      erra_q  <= 1'b0;
      errb_q  <= 1'b0;
    end else begin
      doutb_q <= doutb_d;
      valid_q <= valid_d;
      erra_q  <= erra_d;
      errb_q  <= errb_d;
    end
  end

  assign doutb       = doutb_q;
  assign doutb_valid = valid_q;
  assign erra        = erra_q;
  assign errb        = errb_q;
endmodule

// File: tb/tb_sdp_ram.sv
// Directed bench for sdp_ram: default 32-bit instance via the interface plus a 64-bit/16-deep instance.
module tb_sdp_ram;
  logic clk;
  logic rstn;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  sdp_ram_if #(.DATA_W(32), .ADDR_W(32)) bus ();

  sdp_ram #(.DATA_W(32), .DEPTH(1024), .ADDR_W(32)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .wea         (bus.wea),
    .addra       (bus.addra),
    .dina        (bus.dina),
    .wstrba      (bus.wstrba),
    .reb         (bus.reb),
    .addrb       (bus.addrb),
    .doutb       (bus.doutb),
    .doutb_valid (bus.doutb_valid),
    .erra        (bus.erra),
    .errb        (bus.errb)
  );

  logic        b_wea, b_reb, b_valid, b_erra, b_errb;
  logic [7:0]  b_addra, b_addrb, b_strb;
  logic [63:0] b_din, b_dout;

  sdp_ram #(.DATA_W(64), .DEPTH(16), .ADDR_W(8)) dut64 (
    .clk         (clk),
    .rstn        (rstn),
    .wea         (b_wea),
    .addra       (b_addra),
    .dina        (b_din),
    .wstrba      (b_strb),
    .reb         (b_reb),
    .addrb       (b_addrb),
    .doutb       (b_dout),
    .doutb_valid (b_valid),
    .erra        (b_erra),
    .errb        (b_errb)
  );

  int unsigned checks = 0;
  int unsigned passes = 0;

  logic [31:0] sb [$];
  logic        exp_v, exp_ea, exp_eb;
  logic [31:0] last_q;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    bus.wea    = 1'b1;
    bus.addra  = a;
    bus.dina   = d;
    bus.wstrba = s;
    exp_ea     = (a[1:0] != 2'b00);
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] e);
    bus.reb   = 1'b1;
    bus.addrb = a;
    if (a[1:0] != 2'b00) begin
      exp_eb = 1'b1;
    end else begin
      exp_v = 1'b1;
      sb.push_back(e);
    end
  endtask

  // One clock: check everything the previous drive should have produced, then idle the ports.
  task automatic tick(input string tag);
    logic [31:0] e;
    @(posedge clk);
    #1;
    chk({tag, ".valid"}, 64'(bus.doutb_valid), 64'(exp_v));
    chk({tag, ".erra"},  64'(bus.erra), 64'(exp_ea));
    chk({tag, ".errb"},  64'(bus.errb), 64'(exp_eb));
    if (bus.doutb_valid === 1'b1) begin
      if (sb.size() == 0) begin
        chk({tag, ".sb_empty"}, 64'(1), 64'(0));
      end else begin
        e      = sb.pop_front();
        last_q = e;
      end
    end
    chk({tag, ".doutb"}, 64'(bus.doutb), 64'(last_q));
    bus.wea = 1'b0;
    bus.reb = 1'b0;
    exp_v   = 1'b0;
    exp_ea  = 1'b0;
    exp_eb  = 1'b0;
  endtask

  initial begin
    bus.wea = 1'b0; bus.addra = '0; bus.dina = '0; bus.wstrba = '0;
    bus.reb = 1'b0; bus.addrb = '0;
    b_wea = 1'b0; b_reb = 1'b0; b_addra = '0; b_addrb = '0; b_strb = '0; b_din = '0;
    exp_v = 1'b0; exp_ea = 1'b0; exp_eb = 1'b0; last_q = '0;
    rstn = 1'b1;
    #2 rstn = 1'b0;
    #1;
    chk("rst.doutb", 64'(bus.doutb), 64'(0));
    chk("rst.valid", 64'(bus.doutb_valid), 64'(0));
    chk("rst.erra",  64'(bus.erra), 64'(0));
    chk("rst.errb",  64'(bus.errb), 64'(0));
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;

    wr(32'h10, 32'hDEADBEEF, 4'hF);       tick("wr_full");
    rd(32'h10, 32'hDEADBEEF);             tick("rd_full");
    tick("idle_after_rd");

    wr(32'h10, 32'h11223344, 4'h5);       tick("wr_strb5");
    rd(32'h10, 32'hDE22BE44);             tick("rd_strb5");

    wr(32'h10, 32'hDEADBEEF, 4'hF);       tick("restore");
    wr(32'h12, 32'hA5A5A5A5, 4'hF);       tick("wr_misalign");
    rd(32'h13, 32'h0);                    tick("rd_misalign");
    rd(32'h10, 32'hDEADBEEF);             tick("rd_after_misalign");
    wr(32'h11, 32'h0, 4'hF);
    rd(32'h22, 32'h0);                    tick("both_misalign");

`ifdef SDP_RAM_BYPASS_EN
    wr(32'h10, 32'h0, 4'h3); rd(32'h10, 32'hDEAD0000); tick("collide");
`else
    wr(32'h10, 32'h0, 4'h3); rd(32'h10, 32'hDEADBEEF); tick("collide");
`endif
    rd(32'h10, 32'hDEAD0000);             tick("rd_post_collide");
    wr(32'h10, 32'hFFFFFFFF, 4'h0);       tick("wr_nostrb");
    rd(32'h10, 32'hDEAD0000);             tick("rd_nostrb");

    wr(32'h1010, 32'h0000CAFE, 4'hF);     tick("wr_wrap");
    rd(32'h0010, 32'h0000CAFE);           tick("rd_wrap");
    rd(32'hFFFFF010, 32'h0000CAFE);       tick("rd_wrap_hi");

    for (int i = 0; i < 8; i++) begin
      wr(32'h100 + 32'(4 * i), 32'hC0DE0000 + 32'(i), 4'hF);
      if (i > 0) rd(32'h100 + 32'(4 * (i - 1)), 32'hC0DE0000 + 32'(i - 1));
      tick("stream");
    end
    rd(32'h11C, 32'hC0DE0007);            tick("stream_last");

    // Reset lands in the cycle after a read is issued; that read must vanish.
    wr(32'h30, 32'h0BADF00D, 4'hF);       tick("wr_pre_rst");
    bus.reb = 1'b1; bus.addrb = 32'h10;
    @(posedge clk);
    #1;
    bus.reb = 1'b0;
    rstn = 1'b0;
    #1;
    chk("midrd.doutb", 64'(bus.doutb), 64'(0));
    chk("midrd.valid", 64'(bus.doutb_valid), 64'(0));
    bus.wea = 1'b1; bus.addra = 32'h30; bus.dina = 32'h12345678; bus.wstrba = 4'hF;
    repeat (2) @(posedge clk);
    #1;
    bus.wea = 1'b0;
    rstn = 1'b1;
    last_q = '0;
    tick("post_rst");
    rd(32'h30, 32'h0BADF00D);             tick("rd_rst_write");
    chk("sb_drained", 64'(sb.size()), 64'(0));

    b_wea = 1'b1; b_addra = 8'h08; b_din = 64'h1111111111111111; b_strb = 8'hFF;
    @(posedge clk); #1;
    b_din = 64'hFFEEDDCCBBAA9988; b_strb = 8'hF0;
    @(posedge clk); #1;
    b_wea = 1'b0; b_reb = 1'b1; b_addrb = 8'h88;
    @(posedge clk); #1;
    chk("w64.valid", 64'(b_valid), 64'(1));
    chk("w64.upper", b_dout, 64'hFFEEDDCC11111111);
    b_addrb = 8'h0C; b_wea = 1'b1; b_addra = 8'h04; b_strb = 8'hFF;
    @(posedge clk); #1;
    b_reb = 1'b0; b_wea = 1'b0;
    chk("w64.errb",  64'(b_errb), 64'(1));
    chk("w64.erra",  64'(b_erra), 64'(1));
    chk("w64.valid0", 64'(b_valid), 64'(0));
    chk("w64.hold",  b_dout, 64'hFFEEDDCC11111111);
    @(posedge clk); #1;
    chk("w64.errb_clr", 64'(b_errb), 64'(0));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
